vga_frame_update_scheduler: RTL
===============================

# vga_frame_update_scheduler

Schedules PicoBlaze writes to the VGA pointer memory so that they land only during vertical sync, which prevents mid-frame tearing. Port writes (address on port 40, data on port 41) are queued in a small FIFO. The FIFO is drained one entry per clock into the pointer-memory write interface (MemAddr/MemData/Write) while VSync is low. The block sits between the PicoBlaze I/O bus and the pointer block, and replaces direct port-to-memory latching.

## Interface
- FIFO_DEPTH, 8, entries of {addr[3:0], data[7:0]}; power of two, 2..16
- ADDR_PORT, 8'd40, Port_ID that stages the pointer address
- DATA_PORT, 8'd41, Port_ID that pushes {staged addr, IN_DATA}
- CTRL_PORT, 8'd42, control: bit0 force commit, bit1 clear overflow
- STAT_PORT, 8'd3, Port_ID of the readable status byte

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high
- Port_ID  in  8  PicoBlaze port address
- IN_DATA  in  8  PicoBlaze write data
- Write_Strobe  in  1  PicoBlaze write qualifier
- Read_Strobe  in  1  PicoBlaze read qualifier
- VSync  in  1  active-low vertical sync from the sync counters, synchronous to CLK
- OUT_DATA  out  8  status byte, combinational
- MemAddr  out  4  registered pointer-memory address
- MemData  out  8  registered pointer-memory data
- Write  out  1  registered one-cycle write pulse per committed entry

## Operation
- Staged address register: loaded from IN_DATA[3:0] on Write_Strobe with Port_ID==ADDR_PORT. Reset value 4'hF.
- Push: Write_Strobe with Port_ID==DATA_PORT enqueues {staged addr, IN_DATA}.
  - If the FIFO is full, the push is dropped and the sticky overflow flag is set.
  - The staged address is not auto-incremented.
- Control write (CTRL_PORT):
  - bit1=1 clears overflow.
  - bit0: see Configuration.
- States:
  - IDLE: Write=0. Goes to DRAIN on a VSync falling edge (VSync sampled 0, previous sample 1). Goes to FORCE on a force request. The FIFO may be empty at the falling edge; DRAIN then exits on the next edge.
  - DRAIN: each edge with the FIFO non-empty and VSync sampled 0, pop the head into MemAddr/MemData and set Write=1. Returns to IDLE when the FIFO is empty or VSync is sampled 1. Entries that remain wait for the next frame.
  - FORCE: pops one entry per edge regardless of VSync. Returns to IDLE when empty.
- Simultaneous push and pop in the same cycle: both occur; count is unchanged. A push into a full FIFO in the same cycle as a pop is accepted.
- Status byte: OUT_DATA = {count[3:0], overflow, draining (state≠IDLE), full, empty} when Read_Strobe && Port_ID==STAT_PORT, else 8'hFF.
- Reset state: IDLE, FIFO flushed (count=0), overflow=0, Write=0, MemAddr=4'hF, MemData=8'h00, VSync history=1. Reset mid-drain: Write is 0 from the next edge and the queued entries are discarded.

## Timing
- A push is visible in count on the edge after the strobe cycle.
- VSync is first sampled low at edge E0, which moves the state to DRAIN. The first Write pulse is registered at E1. Consecutive entries produce back-to-back Write pulses, one per cycle.
- MemAddr/MemData hold their last committed value while Write=0.
- A drain pops at most FIFO_DEPTH entries plus any entries pushed during the drain.
- OUT_DATA has zero latency relative to Read_Strobe/Port_ID.

## Configuration
- VGA_SCHED_FORCE_COMMIT_EN defined: a CTRL_PORT write with bit0=1 while in IDLE enters FORCE on the next edge. If it arrives during DRAIN, it is ignored.
- Not defined: bit0 is ignored, FORCE is unreachable, and commits happen only in vertical sync. bit1 (overflow clear) works in both builds.

## Test plan
- Reset, then read STAT_PORT -> OUT_DATA=8'h01; MemAddr=F, MemData=00, Write=0.
- Sequence: port 40←3, port 41←AA, port 40←7, port 41←55, then a VSync low pulse lasting 10 cycles -> two consecutive Write pulses carrying (3,AA) then (7,55), the first at E1. Status afterwards = 8'h01.
- Nine pushes with VSync held high -> count=8, full=1, overflow=1 (status 8'h8A). Write port 42←02 -> status 8'h82. The first 8 entries drain in order on the next VSync low.
- Five entries queued, VSync low for sampled edges E0..E2 -> exactly 2 Write pulses and count=3. The remaining 3 entries commit on the following VSync low.
- Push during DRAIN with the FIFO at count 2 -> the pushed entry is committed in the same window, in FIFO order.
- With VGA_SCHED_FORCE_COMMIT_EN and 2 entries queued, write port 42←01 with VSync high -> 2 Write pulses starting 2 edges later. Without the macro -> no Write pulses.
- RESET asserted mid-drain with 4 entries left -> Write=0 on the next edge, count=0, and no Write pulse on the following VSync.

Source files
------------

// File: rtl/vga_frame_update_scheduler.sv
// Queues PicoBlaze pointer-memory writes and commits them only while VSync is low, so no frame tears.
// Build option: define VGA_SCHED_FORCE_COMMIT_EN to let CTRL_PORT bit0 commit the queue immediately.

module vga_frame_update_scheduler #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  ADDR_PORT  = 8'd40,
  parameter logic [7:0]  DATA_PORT  = 8'd41,
  parameter logic [7:0]  CTRL_PORT  = 8'd42,
  parameter logic [7:0]  STAT_PORT  = 8'd3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] Port_ID,
  input  logic [7:0] IN_DATA,
  input  logic       Write_Strobe,
  input  logic       Read_Strobe,
  input  logic       VSync,
  output logic [7:0] OUT_DATA,
  output logic [3:0] MemAddr,
  output logic [7:0] MemData,
  output logic       Write
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FORCE
  } state_t;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } entry_t;

  state_t           state_q;
  state_t           state_d;
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       staged_addr;
  logic             overflow;
  logic             vsync_prev;

  logic             wr_addr_port;
  logic             wr_data_port;
  logic             wr_ctrl_port;
  logic             force_req;
  logic             vsync_fall;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic [3:0]       count_nib;

  assign wr_addr_port = Write_Strobe && (Port_ID == ADDR_PORT);
  assign wr_data_port = Write_Strobe && (Port_ID == DATA_PORT);
  assign wr_ctrl_port = Write_Strobe && (Port_ID == CTRL_PORT);

`ifdef VGA_SCHED_FORCE_COMMIT_EN
  assign force_req = wr_ctrl_port && IN_DATA[0];
`else
  assign force_req = 1'b0;
`endif

  assign vsync_fall = !VSync && vsync_prev;
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);

  // A pop frees a slot this very edge, so a push into a full FIFO is still accepted.
  assign push = wr_data_port && (!full || pop);

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, otherwise the paths
  // that leave it untouched would infer latches.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vsync_fall)     state_d = ST_DRAIN;
        else if (force_req) state_d = ST_FORCE;
      end
      ST_DRAIN: begin
        if (VSync || empty) state_d = ST_IDLE;
        else                pop     = 1'b1;
      end
      ST_FORCE: begin
        if (empty) state_d = ST_IDLE;
        else       pop     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the entry storage carries no reset; only pointers and count define
  // what is valid, so a reset flush is just clearing those.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{addr: staged_addr, data: IN_DATA};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      staged_addr <= 4'hF;
      overflow    <= 1'b0;
      vsync_prev  <= 1'b1;
      MemAddr     <= 4'hF;
      MemData     <= 8'h00;
      Write       <= 1'b0;
    end else begin
      vsync_prev <= VSync;
      Write      <= pop;

      if (wr_addr_port) staged_addr <= IN_DATA[3:0];

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);

      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        MemAddr <= mem[rd_ptr].addr;
        MemData <= mem[rd_ptr].data;
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (wr_data_port && !push)          overflow <= 1'b1;
      else if (wr_ctrl_port && IN_DATA[1]) overflow <= 1'b0;
    end
  end

  assign count_nib = 4'(count);

  always_comb begin
    OUT_DATA = 8'hFF;
    if (Read_Strobe && (Port_ID == STAT_PORT))
      OUT_DATA = {count_nib, overflow, (state_q != ST_IDLE), full, empty};
  end

endmodule
